// File: rtl/bitty_pkg.sv
// rtl/bitty_pkg.sv - shared fetch/control state encoding and default constants
package bitty_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [15:0] HALT_INSTR_DEFAULT = 16'hFFFF;
  localparam int          TIMEOUT_DEFAULT    = 16;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - EXEC-cycle counter that flags a control unit that never reports done
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic active,
  output logic expire
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Restart on every EXEC entry, then count each EXEC cycle that passes without done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (active) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires on the cycle whose increment would reach TIMEOUT, so the FSM leaves EXEC on that edge
  assign expire = active && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch/execute sequencer; watchdog compiled in with FETCH_TIMEOUT_EN
module fetch_unit
  import bitty_pkg::*;
#(
  parameter int          ADDR_W     = 8,
  parameter logic [15:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter int          TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              error
);

  fetch_state_t state, next_state;
  logic         start_ok;
  logic         capture;
  logic         is_halt;
  logic         exec_done;
  logic         timeout;

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_HALT));
  assign capture   = (state == ST_FETCH) && mem_valid;
  assign is_halt   = (mem_rdata == HALT_INSTR);
  assign exec_done = (state == ST_EXEC) && done;
  assign mem_addr  = pc;

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (capture && !is_halt),
    .active ((state == ST_EXEC) && !done),
    .expire (timeout)
  );

  // Fault flag stays set until reset or an accepted start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error <= 1'b0;
    end else if (start_ok) begin
      error <= 1'b0;
    end else if (timeout) begin
      error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection; done wins over a same-cycle watchdog expiry
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE, ST_HALT: if (start) next_state = ST_FETCH;
      ST_FETCH:         if (mem_valid) next_state = is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (done) begin
          next_state = ST_FETCH;
        end else if (timeout) begin
          next_state = ST_HALT;
        end
      end
      default:          next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next_state and registered so none depends combinationally on inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      instruction <= '0;
      run         <= 1'b0;
      mem_rd      <= 1'b0;
      halted      <= 1'b0;
    end else begin
      mem_rd <= (next_state == ST_FETCH);
      run    <= (next_state == ST_EXEC);
      halted <= (next_state == ST_HALT);
      if (start_ok) begin
        pc <= '0;
      end else if (exec_done) begin
        pc <= pc + ADDR_W'(1);
      end
      if (capture) begin
        instruction <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8: program-counter and memory-address width.
REQ-002 Parameter HALT_INSTR, default 16'hFFFF: instruction word that stops execution.
REQ-003 Parameter TIMEOUT, default 16: max cycles waiting for done (used only under REQ-030).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse; begins execution from address 0.
REQ-007 mem_rd  output  1  instruction-memory read request.
REQ-008 mem_addr  output  ADDR_W  read address, equals pc.
REQ-009 mem_rdata  input  16  read data, valid when mem_valid=1.
REQ-010 mem_valid  input  1  read-data strobe; arbitrary latency >=0 cycles after mem_rd.
REQ-011 instruction  output  16  word presented to the control unit.
REQ-012 run  output  1  execute request to the control unit.
REQ-013 done  input  1  control-unit completion indication, level-sampled.
REQ-014 pc  output  ADDR_W  current program counter.
REQ-015 halted  output  1  high in HALT state.
REQ-016 error  output  1  watchdog fault flag (REQ-030); tied 0 when compiled out.

Function
REQ-017 States IDLE, FETCH, EXEC, HALT; encoded 2 bits.
REQ-018 IDLE: all outputs 0; start=1 -> pc<=0, next state FETCH.
REQ-019 FETCH: mem_rd=1, mem_addr=pc, held until mem_valid=1 sampled.
REQ-020 FETCH with mem_valid=1: instruction<=mem_rdata; if mem_rdata==HALT_INSTR -> HALT, else -> EXEC; mem_rd=0 the following cycle.
REQ-021 EXEC: run=1, instruction held stable for the whole state.
REQ-022 EXEC with done=1: run<=0, pc<=pc+1 (modulo 2^ADDR_W, wraps max->0), next state FETCH.
REQ-023 Minimum instruction period with zero-latency memory and done on the first EXEC cycle: 2 cycles (FETCH, EXEC).
REQ-024 mem_valid outside FETCH and done outside EXEC are ignored.
REQ-025 HALT: halted=1, run=0, mem_rd=0, pc frozen at halt address; start=1 -> pc<=0, FETCH, halted<=0.
REQ-026 start during FETCH or EXEC is ignored.
REQ-027 All outputs are registered; no combinational input-to-output path.

Reset
REQ-028 reset=0 asynchronously forces state IDLE, pc=0, instruction=0, run=0, mem_rd=0, halted=0, error=0, watchdog counter 0.
REQ-029 Reset mid-EXEC or mid-FETCH abandons the operation; no pc increment; after release, only start resumes.

Configuration
REQ-030 With FETCH_TIMEOUT_EN defined: counter clears on EXEC entry, increments each EXEC cycle without done; on reaching TIMEOUT -> error<=1 (sticky until reset or start), run<=0, HALT.
REQ-031 Without FETCH_TIMEOUT_EN: no counter logic, error constant 0, EXEC waits indefinitely.

Structure
REQ-032 Shared package bitty_pkg holds the state encoding constants and HALT_INSTR default, shared with the control unit bench.
REQ-033 One sub-module fetch_watchdog (counter + compare), instantiated only under FETCH_TIMEOUT_EN.

Verification
REQ-034 Program {16'h0408, 16'h2410, FFFF}, mem latency 0, done 3 cycles after run -> two runs with pc 0,1; halt at pc=2, halted=1.
REQ-035 mem_valid delayed 4 cycles -> mem_rd held 4 cycles, mem_addr stable, run not asserted before capture.
REQ-036 ADDR_W=2, memory with no HALT -> pc sequence 0,1,2,3,0 wrap, continuous runs.
REQ-037 reset pulled low during EXEC with run=1 -> run=0 and state IDLE same cycle, pc=0; start restarts at address 0.
REQ-038 FETCH_TIMEOUT_EN, TIMEOUT=16, done never asserted -> error=1, halted=1 exactly 16 cycles after run rose.
REQ-039 start pulse during EXEC and done asserted in FETCH -> both ignored, pc unchanged.
